branch_killable_queue_mw: RTL and testbench

Multi-wide successor to the single-lane branch-killable queue, used in the DCache/LSU request path. Accepts up to ENQ_WIDTH uop-carrying requests per cycle and dequeues one per cycle. On a mispredict it kills entries whose br_mask hits brupdate.b1.mispredict_mask, and on io_flush it kills entries that use the LDQ. Resolved branches only clear br_mask bits and never kill. Killed entries at the head are dropped automatically, so they never stall the queue.

---
 rtl/bkq_pkg.sv | 65 ++++++
 rtl/bkq_enq_compactor.sv | 35 +++
 rtl/branch_killable_queue_mw.sv | 151 +++++++++++++++
 tb/tb_branch_killable_queue_mw.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bkq_pkg.sv
// Shared types and helpers for the branch-killable queue.
// Branch mask width comes from the global maxBrCount define.
`ifndef maxBrCount
`define maxBrCount 4
`endif

package bkq_pkg;

    localparam int MAX_BR = `maxBrCount;

    typedef logic [MAX_BR-1:0] br_mask_t;

    typedef struct packed {
        br_mask_t   br_mask;
        logic       uses_ldq;
        logic [5:0] rob_idx;
    } micro_op_t;

    typedef struct packed {
        br_mask_t resolve_mask;
        br_mask_t mispredict_mask;
    } br_update_b1_t;

    typedef struct packed {
        br_update_b1_t b1;
    } br_update_t;

    typedef struct packed {
        micro_op_t   uop;
        logic [31:0] addr;
        logic [31:0] data;
    } dcache_req_t;

    function automatic logic isKilledByBranch(
        input br_update_t bu,
        input br_mask_t   m
    );
        return |(m & bu.b1.mispredict_mask);
    endfunction

    function automatic br_mask_t getNewBrMask(
        input br_update_t bu,
        input br_mask_t   m
    );
        return m & ~bu.b1.resolve_mask;
    endfunction

    function automatic logic flush_fn(input micro_op_t u);
        return u.uses_ldq;
    endfunction

    // Number of set bits among the lowest n lanes (at most 4 lanes).
    function automatic logic [2:0] popcount_lanes(
        input logic [3:0] v,
        input int         n
    );
        logic [2:0] c;
        c = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < n && v[k]) c = c + 3'd1;
        end
        return c;
    endfunction

endpackage

// File: rtl/bkq_enq_compactor.sv
// Maps sparse enqueue lanes onto consecutive queue slots.
// Purely combinational; slot indices wrap modulo ENTRIES.
module bkq_enq_compactor
    import bkq_pkg::*;
#(
    parameter int ENTRIES   = 16,
    parameter int ENQ_WIDTH = 2,
    localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
    localparam int CW = $clog2(ENTRIES + 1)
) (
    input  logic [ENQ_WIDTH-1:0] valid,
    input  logic [PW-1:0]        enq_ptr,
    output logic [PW-1:0]        slot [ENQ_WIDTH],
    output logic [ENQ_WIDTH-1:0] wen,
    output logic [CW-1:0]        acc_count
);

    logic [3:0] v4;
    int         idx;

    // Each valid lane takes the next free slot after the lower valid lanes.
    always_comb begin
        v4  = '0;
        idx = 0;
        v4[ENQ_WIDTH-1:0] = valid;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            idx = int'(enq_ptr) + int'(popcount_lanes(v4, i));
            if (idx >= ENTRIES) idx = idx - ENTRIES;
            slot[i] = PW'(idx);
        end
        wen       = valid;
        acc_count = CW'(popcount_lanes(v4, ENQ_WIDTH));
    end

endmodule

// File: rtl/branch_killable_queue_mw.sv
// Multi-wide enqueue, single dequeue queue with branch/flush kill.
// Dead entries at the head are dropped one per cycle.
module branch_killable_queue_mw
    import bkq_pkg::*;
#(
    parameter int  ENTRIES   = 16,
    parameter int  ENQ_WIDTH = 2,
    parameter bit  FLOW      = 1'b0,
    parameter type T         = dcache_req_t,
    localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
    localparam int CW = $clog2(ENTRIES + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_flush,
    input  br_update_t           io_brupdate,
    input  logic [ENQ_WIDTH-1:0] io_enq_valid,
    input  T                     io_enq_bits [ENQ_WIDTH],
    output logic                 io_enq_ready,
    output logic                 io_deq_valid,
    input  logic                 io_deq_ready,
    output T                     io_deq_bits,
    output logic                 io_empty,
    output logic [CW-1:0]        io_count
);

    T                     ram  [ENTRIES];
    micro_op_t            uops [ENTRIES];
    logic [ENTRIES-1:0]   alive;
    logic [PW-1:0]        enq_ptr;
    logic [PW-1:0]        deq_ptr;
    logic [CW-1:0]        count;

    micro_op_t            lane_uop [ENQ_WIDTH];
    logic [ENQ_WIDTH-1:0] lane_live;
    micro_op_t            head_uop;
    micro_op_t            out_uop;
    logic                 head_dead_now;
    logic                 bypass;
    logic                 bypass_take;
    logic                 head_drop;
    logic                 pop;
    logic [ENQ_WIDTH-1:0] comp_valid;
    logic [ENQ_WIDTH-1:0] wen;
    logic [PW-1:0]        slot [ENQ_WIDTH];
    logic [CW-1:0]        acc;
    logic [PW-1:0]        enq_ptr_nxt;
    logic [PW-1:0]        deq_ptr_nxt;
    int                   esum;

    assign io_empty = (count == '0);
    assign io_count = count;
    assign io_enq_ready =
        ({1'b0, count} + (CW+1)'(ENQ_WIDTH)) <= (CW+1)'(ENTRIES);

    bkq_enq_compactor #(
        .ENTRIES   (ENTRIES),
        .ENQ_WIDTH (ENQ_WIDTH)
    ) u_comp (
        .valid     (comp_valid),
        .enq_ptr   (enq_ptr),
        .slot      (slot),
        .wen       (wen),
        .acc_count (acc)
    );

    // Incoming lanes: resolved mask and whether they survive arrival.
    always_comb begin
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            lane_uop[i] = io_enq_bits[i].uop;
            lane_uop[i].br_mask =
                getNewBrMask(io_brupdate, io_enq_bits[i].uop.br_mask);
            lane_live[i] =
                !isKilledByBranch(io_brupdate, io_enq_bits[i].uop.br_mask) &&
                !(io_flush && flush_fn(io_enq_bits[i].uop));
        end
    end

    // Head presentation, bypass, pop and lane gating.
    always_comb begin
        head_uop      = uops[deq_ptr];
        head_dead_now =
            isKilledByBranch(io_brupdate, head_uop.br_mask) ||
            (io_flush && flush_fn(head_uop));
        bypass      = FLOW && io_empty && io_enq_valid[0];
        bypass_take = bypass && (io_deq_ready || !lane_live[0]);
        head_drop   = !io_empty && !alive[deq_ptr];
        if (bypass) begin
            io_deq_valid = lane_live[0];
            io_deq_bits  = io_enq_bits[0];
            out_uop      = lane_uop[0];
        end else begin
            io_deq_valid = !io_empty && alive[deq_ptr] && !head_dead_now;
            io_deq_bits  = ram[deq_ptr];
            out_uop      = head_uop;
            out_uop.br_mask = getNewBrMask(io_brupdate, head_uop.br_mask);
        end
        io_deq_bits.uop = out_uop;
        pop = !io_empty && ((io_deq_valid && io_deq_ready) || head_drop);
        comp_valid = io_enq_ready ? io_enq_valid : '0;
        if (bypass_take) comp_valid[0] = 1'b0;
    end

    // Pointer advance with wrap for arbitrary depths.
    always_comb begin
        esum = int'(enq_ptr) + int'(acc);
        if (esum >= ENTRIES) esum = esum - ENTRIES;
        enq_ptr_nxt = PW'(esum);
        if (int'(deq_ptr) == ENTRIES - 1) deq_ptr_nxt = '0;
        else deq_ptr_nxt = deq_ptr + PW'(1);
    end

    // Control state: pointers, occupancy and per-entry liveness.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enq_ptr <= '0;
            deq_ptr <= '0;
            count   <= '0;
            alive   <= '0;
        end else begin
            for (int j = 0; j < ENTRIES; j++) begin
                alive[j] <= alive[j] &&
                    !isKilledByBranch(io_brupdate, uops[j].br_mask) &&
                    !(io_flush && flush_fn(uops[j]));
            end
            if (pop) begin
                alive[deq_ptr] <= 1'b0;
                deq_ptr        <= deq_ptr_nxt;
            end
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (wen[i]) alive[slot[i]] <= lane_live[i];
            end
            enq_ptr <= enq_ptr_nxt;
            count   <= count + acc - CW'(pop);
        end
    end

    // Payload storage; stored masks track resolutions every cycle.
    always_ff @(posedge clock) begin
        for (int j = 0; j < ENTRIES; j++) begin
            uops[j].br_mask <= getNewBrMask(io_brupdate, uops[j].br_mask);
        end
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (wen[i]) begin
                ram[slot[i]]  <= io_enq_bits[i];
                uops[slot[i]] <= lane_uop[i];
            end
        end
    end

endmodule

// File: tb/tb_branch_killable_queue_mw.sv
// Directed vector bench for branch_killable_queue_mw.
// Depth 6, two lanes, flow-through enabled.
module tb_branch_killable_queue_mw;
    import bkq_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_flush;
    br_update_t  io_brupdate;
    logic [1:0]  io_enq_valid;
    dcache_req_t io_enq_bits [2];
    logic        io_enq_ready;
    logic        io_deq_valid;
    logic        io_deq_ready;
    dcache_req_t io_deq_bits;
    logic        io_empty;
    logic [2:0]  io_count;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    branch_killable_queue_mw #(
        .ENTRIES   (6),
        .ENQ_WIDTH (2),
        .FLOW      (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_flush     (io_flush),
        .io_brupdate  (io_brupdate),
        .io_enq_valid (io_enq_valid),
        .io_enq_bits  (io_enq_bits),
        .io_enq_ready (io_enq_ready),
        .io_deq_valid (io_deq_valid),
        .io_deq_ready (io_deq_ready),
        .io_deq_bits  (io_deq_bits),
        .io_empty     (io_empty),
        .io_count     (io_count)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] d0;
        logic [3:0]  m0;
        logic        l0;
        logic [31:0] d1;
        logic [3:0]  m1;
        logic        l1;
        logic        rdy;
        logic        fl;
        logic [3:0]  misp;
        logic [3:0]  res;
        logic        e_dv;
        logic [31:0] e_data;
        logic [3:0]  e_mask;
        int          e_cnt;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic dcache_req_t mk(
        input logic [31:0] d, input logic [3:0] m, input logic l
    );
        dcache_req_t r;
        r = '0;
        r.data = d;
        r.addr = d + 32'h1000;
        r.uop.br_mask = m;
        r.uop.uses_ldq = l;
        r.uop.rob_idx = d[5:0];
        return r;
    endfunction

    function automatic vec_t v(
        input logic [1:0] valid,
        input logic [31:0] d0, input logic [3:0] m0, input logic l0,
        input logic [31:0] d1, input logic [3:0] m1, input logic l1,
        input logic rdy, input logic fl,
        input logic [3:0] misp, input logic [3:0] res,
        input logic e_dv, input logic [31:0] e_data,
        input logic [3:0] e_mask, input int e_cnt, input logic e_rdy
    );
        vec_t x;
        x.valid = valid; x.d0 = d0; x.m0 = m0; x.l0 = l0;
        x.d1 = d1; x.m1 = m1; x.l1 = l1;
        x.rdy = rdy; x.fl = fl; x.misp = misp; x.res = res;
        x.e_dv = e_dv; x.e_data = e_data; x.e_mask = e_mask;
        x.e_cnt = e_cnt; x.e_rdy = e_rdy;
        return x;
    endfunction

    task automatic chk(
        input string name, input logic [31:0] act, input logic [31:0] exp
    );
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input vec_t x);
        io_enq_valid   = x.valid;
        io_enq_bits[0] = mk(x.d0, x.m0, x.l0);
        io_enq_bits[1] = mk(x.d1, x.m1, x.l1);
        io_deq_ready   = x.rdy;
        io_flush       = x.fl;
        io_brupdate.b1.mispredict_mask = x.misp;
        io_brupdate.b1.resolve_mask    = x.res;
    endtask

    task automatic check_row(input int n, input vec_t x);
        chk($sformatf("row%0d count", n), 32'(io_count), 32'(x.e_cnt));
        chk($sformatf("row%0d empty", n), 32'(io_empty),
            32'(x.e_cnt == 0));
        chk($sformatf("row%0d enq_ready", n), 32'(io_enq_ready),
            32'(x.e_rdy));
        chk($sformatf("row%0d deq_valid", n), 32'(io_deq_valid),
            32'(x.e_dv));
        if (x.e_dv) begin
            chk($sformatf("row%0d data", n), io_deq_bits.data, x.e_data);
            chk($sformatf("row%0d br_mask", n),
                32'(io_deq_bits.uop.br_mask), 32'(x.e_mask));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drive(v(2'b00, 0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0,1));
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("reset empty", 32'(io_empty), 32'd1);
        chk("reset count", 32'(io_count), 32'd0);
        chk("reset enq_ready", 32'(io_enq_ready), 32'd1);
        chk("reset deq_valid", 32'(io_deq_valid), 32'd0);

        // fill to full, reject at full, drain with wrap
        vecs.push_back(v(2'b11,'h10,0,0,'h11,0,0, 0,0,0,0, 1,'h10,0,0,1));
        vecs.push_back(v(2'b11,'h12,0,0,'h13,0,0, 0,0,0,0, 1,'h10,0,2,1));
        vecs.push_back(v(2'b11,'h14,0,0,'h15,0,0, 0,0,0,0, 1,'h10,0,4,1));
        vecs.push_back(v(2'b11,'h99,0,0,'h98,0,0, 0,0,0,0, 1,'h10,0,6,0));
        vecs.push_back(v(2'b11,'h90,0,0,'h91,0,0, 1,0,0,0, 1,'h10,0,6,0));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       1,0,0,0, 1,'h11,0,5,0));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       1,0,0,0, 1,'h12,0,4,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       1,0,0,0, 1,'h13,0,3,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       1,0,0,0, 1,'h14,0,2,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       1,0,0,0, 1,'h15,0,1,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       0,0,0,0, 0,0,0,0,1));
        // sparse lane 1 only
        vecs.push_back(v(2'b10,'h77,0,0,'hA0,0,0, 0,0,0,0, 0,0,0,0,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       0,0,0,0, 1,'hA0,0,1,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       1,0,0,0, 1,'hA0,0,1,1));
        // mispredict kills mask 0001, resolve clears 0010
        vecs.push_back(v(2'b11,'h20,1,0,'h21,2,0, 0,0,0,0, 1,'h20,1,0,1));
        vecs.push_back(v(2'b01,'h22,1,0,0,0,0,    0,0,0,0, 1,'h20,1,2,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       0,0,1,2, 0,0,0,3,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       1,0,0,0, 0,0,0,3,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       1,0,0,0, 1,'h21,0,2,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       1,0,0,0, 0,0,0,1,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       0,0,0,0, 0,0,0,0,1));
        // flush kills LDQ users
        vecs.push_back(v(2'b11,'h30,0,1,'h31,0,0, 0,0,0,0, 1,'h30,0,0,1));
        vecs.push_back(v(2'b01,'h32,0,1,0,0,0,    0,0,0,0, 1,'h30,0,2,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       0,1,0,0, 0,0,0,3,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       1,0,0,0, 0,0,0,3,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       1,0,0,0, 1,'h31,0,2,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       1,0,0,0, 0,0,0,1,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       0,0,0,0, 0,0,0,0,1));
        // flow-through bypass
        vecs.push_back(v(2'b01,'h40,0,0,0,0,0,    1,0,0,0, 1,'h40,0,0,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       0,0,0,0, 0,0,0,0,1));
        vecs.push_back(v(2'b01,'h41,1,0,0,0,0,    0,0,1,0, 0,0,0,0,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       0,0,0,0, 0,0,0,0,1));
        vecs.push_back(v(2'b11,'h50,0,0,'h51,0,0, 1,0,0,0, 1,'h50,0,0,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       1,0,0,0, 1,'h51,0,1,1));
        vecs.push_back(v(2'b00,0,0,0,0,0,0,       0,0,0,0, 0,0,0,0,1));

        foreach (vecs[n]) begin
            drive(vecs[n]);
            #3;
            check_row(n, vecs[n]);
            @(posedge clock);
            #1;
        end

        // reset asserted with data in flight
        drive(v(2'b11,'h60,0,0,'h61,0,0, 0,0,0,0, 0,0,0,0,1));
        @(posedge clock);
        #1;
        chk("midrst pre count", 32'(io_count), 32'd2);
        io_enq_valid = 2'b00;
        reset = 1'b0;
        #1;
        chk("midrst count", 32'(io_count), 32'd0);
        chk("midrst empty", 32'(io_empty), 32'd1);
        chk("midrst enq_ready", 32'(io_enq_ready), 32'd1);
        chk("midrst deq_valid", 32'(io_deq_valid), 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        io_deq_ready = 1'b1;
        #2;
        chk("postrst count", 32'(io_count), 32'd0);
        chk("postrst deq_valid", 32'(io_deq_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
